// File: rtl/s2_kes_sched_pkg.sv
// rtl/s2_kes_sched_pkg.sv - shared encodings and constants for the KES job scheduler
package s2_kes_sched_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_LAUNCH = 4'b0010,
    ST_WAIT   = 4'b0100,
    ST_OUT    = 4'b1000
  } kes_state_e;

  localparam logic [23:0] BYPASS_LAMBDA = 24'h000001;
  localparam int          KES_TIMEOUT   = 8;
  localparam int          KES_LATENCY   = 5;

  localparam int SYN_W    = 8;
  localparam int SYN0_LSB = 0;
  localparam int SYN1_LSB = 8;
  localparam int SYN2_LSB = 16;
  localparam int SYN3_LSB = 24;

  function automatic logic [SYN_W-1:0] syn_field(input logic [31:0] word, input int lsb);
    return word[lsb +: SYN_W];
  endfunction

endpackage

// File: rtl/s2_kes_rr_arb2.sv
// rtl/s2_kes_rr_arb2.sv - two-way round-robin arbiter for the scheduler request lanes
module s2_kes_rr_arb2 (
  input  logic clk,
  input  logic rstn,
  input  logic valid0,
  input  logic valid1,
  input  logic advance,
  output logic grant,
  output logic grant_lane,
  output logic pointer
);

  always_comb begin
    grant      = valid0 | valid1;
    grant_lane = (valid0 && valid1) ? pointer : valid1;
  end

  // The pointer only turns over when a grant is actually taken.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pointer <= 1'b0;
    end else if (advance && grant) begin
      pointer <= ~grant_lane;
    end
  end

endmodule

// File: rtl/s2_kes_sched.sv
// rtl/s2_kes_sched.sv - two-lane syndrome job scheduler in front of a key-equation solver
module s2_kes_sched
  import s2_kes_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_syn,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_syn,
  output logic        kes_ena,
  output logic [7:0]  kes_syn0,
  output logic [7:0]  kes_syn1,
  output logic [7:0]  kes_syn2,
  output logic [7:0]  kes_syn3,
  input  logic        kes_done,
  input  logic [7:0]  kes_lambda0,
  input  logic [7:0]  kes_lambda1,
  input  logic [7:0]  kes_lambda2,
  input  logic [7:0]  kes_omega0,
  input  logic [7:0]  kes_omega1,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_lane,
  output logic [23:0] res_lambda,
  output logic [15:0] res_omega,
  output logic        res_bypass,
  output logic        res_timeout,
  output logic        busy
);

  localparam logic [2:0] WD_LAST = 3'(KES_TIMEOUT - 1);

  kes_state_e  state, nxt;
  logic [31:0] syn_q;
  logic [2:0]  wdog;
  logic        grant, grant_lane, rr_pointer;
  logic        accept, sel_zero;
  logic [31:0] sel_syn;

  s2_kes_rr_arb2 u_arb (
    .clk       (clk),
    .rstn      (rstn),
    .valid0    (req0_valid),
    .valid1    (req1_valid),
    .advance   (accept),
    .grant     (grant),
    .grant_lane(grant_lane),
    .pointer   (rr_pointer)
  );

  // rstn gates ready so nothing looks accepted while the block is held in reset.
  assign accept     = rstn && (state == ST_IDLE) && grant;
  assign req0_ready = accept && !grant_lane;
  assign req1_ready = accept && grant_lane;
  assign sel_syn    = grant_lane ? req1_syn : req0_syn;
  assign sel_zero   = (sel_syn == 32'h0);

  assign kes_ena   = (state == ST_LAUNCH);
  assign res_valid = (state == ST_OUT);
  assign busy      = (state != ST_IDLE);
  assign kes_syn0  = syn_field(syn_q, SYN0_LSB);
  assign kes_syn1  = syn_field(syn_q, SYN1_LSB);
  assign kes_syn2  = syn_field(syn_q, SYN2_LSB);
  assign kes_syn3  = syn_field(syn_q, SYN3_LSB);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:   if (grant) nxt = sel_zero ? ST_OUT : ST_LAUNCH;
      ST_LAUNCH: nxt = ST_WAIT;
      ST_WAIT:   if (kes_done || wdog == WD_LAST) nxt = ST_OUT;
      ST_OUT:    if (res_ready) nxt = ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase
  end

  // kes_done wins over watchdog expiry when both land in the same WAIT cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      syn_q       <= '0;
      wdog        <= '0;
      res_lane    <= 1'b0;
      res_lambda  <= '0;
      res_omega   <= '0;
      res_bypass  <= 1'b0;
      res_timeout <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (grant) begin
          syn_q       <= sel_syn;
          res_lane    <= grant_lane;
          res_lambda  <= sel_zero ? BYPASS_LAMBDA : 24'h0;
          res_omega   <= '0;
          res_bypass  <= sel_zero;
          res_timeout <= 1'b0;
        end
        ST_LAUNCH: wdog <= '0;
        ST_WAIT: begin
          if (kes_done) begin
            res_lambda <= {kes_lambda2, kes_lambda1, kes_lambda0};
            res_omega  <= {kes_omega1, kes_omega0};
          end else if (wdog == WD_LAST) begin
            res_lambda  <= '0;
            res_omega   <= '0;
            res_timeout <= 1'b1;
          end else begin
            wdog <= wdog + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (!rstn)
    (accept && req0_valid && req1_valid) |-> (grant_lane == rr_pointer));

endmodule

// File: tb/tb_s2_kes_sched.sv
// tb/tb_s2_kes_sched.sv - directed table-driven bench for s2_kes_sched
module tb_s2_kes_sched;
  import s2_kes_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_syn = '0, req1_syn = '0;
  logic        kes_ena;
  logic [7:0]  kes_syn0, kes_syn1, kes_syn2, kes_syn3;
  logic        kes_done = 1'b0;
  logic [7:0]  kes_lambda0 = '0, kes_lambda1 = '0, kes_lambda2 = '0;
  logic [7:0]  kes_omega0 = '0, kes_omega1 = '0;
  logic        res_valid, res_ready = 1'b0;
  logic        res_lane, res_bypass, res_timeout, busy;
  logic [23:0] res_lambda;
  logic [15:0] res_omega;

  s2_kes_sched dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_syn(req0_syn),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_syn(req1_syn),
    .kes_ena(kes_ena), .kes_syn0(kes_syn0), .kes_syn1(kes_syn1),
    .kes_syn2(kes_syn2), .kes_syn3(kes_syn3),
    .kes_done(kes_done), .kes_lambda0(kes_lambda0), .kes_lambda1(kes_lambda1),
    .kes_lambda2(kes_lambda2), .kes_omega0(kes_omega0), .kes_omega1(kes_omega1),
    .res_valid(res_valid), .res_ready(res_ready), .res_lane(res_lane),
    .res_lambda(res_lambda), .res_omega(res_omega), .res_bypass(res_bypass),
    .res_timeout(res_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_lane_q[$];
  int acc_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rstn) begin
      if (req0_valid && req0_ready) begin acc_lane_q.push_back(0); acc_cyc_q.push_back(cyc); end
      if (req1_valid && req1_ready) begin acc_lane_q.push_back(1); acc_cyc_q.push_back(cyc); end
    end
  end

  // Stub engine: done eng_dly cycles after kes_ena (0 = never); results are a fixed mix of the syndromes.
  int          eng_dly = KES_LATENCY;
  int          eng_cnt = 0;
  logic [31:0] eng_syn = '0;
  always @(negedge clk) begin
    kes_done = 1'b0;
    if (kes_ena) begin
      eng_syn = {kes_syn3, kes_syn2, kes_syn1, kes_syn0};
      eng_cnt = eng_dly;
    end else if (eng_cnt > 0) begin
      eng_cnt = eng_cnt - 1;
      if (eng_cnt == 0) kes_done = 1'b1;
    end
    kes_lambda0 = 8'h01;
    kes_lambda1 = eng_syn[7:0] ^ eng_syn[15:8];
    kes_lambda2 = eng_syn[23:16] ^ eng_syn[31:24];
    kes_omega0  = eng_syn[7:0];
    kes_omega1  = eng_syn[31:24] ^ 8'hFF;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    logic        lane;
    logic [31:0] syn;
    int          dly;
    int          lat;
    logic [23:0] lam;
    logic [15:0] om;
    logic        byp;
    logic        tmo;
  } vec_t;

  task automatic run_job(input vec_t v, input int idx);
    int   n;
    int   ena_cnt;
    logic got;
    eng_dly = v.dly;
    if (v.lane) begin req1_valid = 1'b1; req1_syn = v.syn; end
    else        begin req0_valid = 1'b1; req0_syn = v.syn; end
    #1;
    chk($sformatf("v%0d ready", idx), {31'd0, v.lane ? req1_ready : req0_ready}, 32'd1);
    n = 0; ena_cnt = 0; got = 1'b0;
    while (n < 20 && !got) begin
      step();
      n++;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      if (kes_ena) begin
        ena_cnt++;
        chk($sformatf("v%0d kes_syn", idx), {kes_syn3, kes_syn2, kes_syn1, kes_syn0}, v.syn);
      end
      if (res_valid) got = 1'b1;
    end
    chk($sformatf("v%0d latency", idx), n, v.lat);
    chk($sformatf("v%0d lane", idx), {31'd0, res_lane}, {31'd0, v.lane});
    chk($sformatf("v%0d lambda", idx), {8'd0, res_lambda}, {8'd0, v.lam});
    chk($sformatf("v%0d omega", idx), {16'd0, res_omega}, {16'd0, v.om});
    chk($sformatf("v%0d flags", idx), {30'd0, res_bypass, res_timeout}, {30'd0, v.byp, v.tmo});
    chk($sformatf("v%0d ena_count", idx), ena_cnt, v.byp ? 0 : 1);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk($sformatf("v%0d idle_after", idx), {31'd0, busy}, 32'd0);
  endtask

  vec_t vt[9];

  initial begin
    int   base;
    int   n;
    logic bad;

    vt[0] = '{1'b0, 32'h00000000, 5,  1, 24'h000001, 16'h0000, 1'b1, 1'b0};
    vt[1] = '{1'b1, 32'h1D0C3A7B, 5,  7, 24'h114101, 16'hE27B, 1'b0, 1'b0};
    vt[2] = '{1'b0, 32'h00000100, 5,  7, 24'h000101, 16'hFF00, 1'b0, 1'b0};
    vt[3] = '{1'b1, 32'h00000000, 5,  1, 24'h000001, 16'h0000, 1'b1, 1'b0};
    vt[4] = '{1'b0, 32'h80000000, 0, 10, 24'h000000, 16'h0000, 1'b0, 1'b1};
    vt[5] = '{1'b1, 32'hA5A5A5A5, 5,  7, 24'h000001, 16'h5AA5, 1'b0, 1'b0};
    vt[6] = '{1'b0, 32'hFFFFFFFF, 5,  7, 24'h000001, 16'h00FF, 1'b0, 1'b0};
    vt[7] = '{1'b1, 32'h01020304, 8, 10, 24'h030701, 16'hFE04, 1'b0, 1'b0};
    vt[8] = '{1'b0, 32'h01020304, 9, 10, 24'h000000, 16'h0000, 1'b0, 1'b1};

    // Reset state, with requests pending on both lanes
    rstn = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    req0_syn = 32'h12345678; req1_syn = 32'h9ABCDEF0; res_ready = 1'b1;
    repeat (3) step();
    chk("rst ready", {30'd0, req0_ready, req1_ready}, 32'd0);
    chk("rst ctl", {29'd0, kes_ena, res_valid, busy}, 32'd0);
    chk("rst kes_syn", {kes_syn3, kes_syn2, kes_syn1, kes_syn0}, 32'd0);
    chk("rst res", {res_lambda, res_omega[7:0]} | {16'd0, res_omega}, 32'd0);
    chk("rst flags", {29'd0, res_lane, res_bypass, res_timeout}, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
    rstn = 1'b1;
    step();

    for (int i = 0; i < 9; i++) run_job(vt[i], i);

    // Round robin with both lanes requesting and res_ready tied high
    rstn = 1'b0; step(); rstn = 1'b1; step();
    eng_dly = KES_LATENCY;
    base = acc_lane_q.size();
    req0_syn = 32'h11111111; req1_syn = 32'h22222222;
    req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
    n = 0;
    while (n < 60 && acc_lane_q.size() < base + 4) begin step(); n++; end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rr accepts", acc_lane_q.size() - base, 4);
    if (acc_lane_q.size() >= base + 4) begin
      for (int k = 0; k < 4; k++) chk($sformatf("rr lane%0d", k), acc_lane_q[base + k], k % 2);
      for (int k = 1; k < 4; k++) chk($sformatf("rr gap%0d", k), acc_cyc_q[base + k] - acc_cyc_q[base + k - 1], 8);
    end
    n = 0;
    while (n < 40 && busy) begin step(); n++; end
    chk("rr drain", {31'd0, busy}, 32'd0);
    res_ready = 1'b0;

    // Result held in OUT while res_ready stays low; no request may slip in
    eng_dly = KES_LATENCY;
    req0_syn = 32'h1D0C3A7B; req0_valid = 1'b1;
    step(); req0_valid = 1'b0;
    n = 0;
    while (n < 20 && !res_valid) begin step(); n++; end
    base = acc_lane_q.size();
    req0_valid = 1'b1; req1_valid = 1'b1; req1_syn = 32'h0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d ctl", k), {26'd0, res_valid, req0_ready, req1_ready, res_lane, res_bypass, res_timeout}, 32'h20);
      chk($sformatf("stall%0d data", k), {res_lambda, res_omega[15:8]}, 32'h114101E2);
      chk($sformatf("stall%0d om0", k), {24'd0, res_omega[7:0]}, 32'h7B);
      step();
    end
    chk("stall no accept", acc_lane_q.size() - base, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    res_ready = 1'b1; step(); res_ready = 1'b0;
    chk("stall release", {31'd0, busy}, 32'd0);

    // Reset pulsed in WAIT; the engine's late kes_done must not produce a result
    eng_dly = KES_LATENCY;
    req1_syn = 32'h0000FF00; req1_valid = 1'b1;
    step(); req1_valid = 1'b0;
    chk("wrst launch", {31'd0, kes_ena}, 32'd1);
    step(); step();
    chk("wrst in_wait", {30'd0, busy, kes_ena}, 32'h2);
    rstn = 1'b0;
    #1;
    chk("wrst ctl", {29'd0, kes_ena, res_valid, busy}, 32'd0);
    chk("wrst kes_syn", {kes_syn3, kes_syn2, kes_syn1, kes_syn0}, 32'd0);
    chk("wrst res", {8'd0, res_lambda} | {16'd0, res_omega}, 32'd0);
    chk("wrst flags", {29'd0, res_lane, res_bypass, res_timeout}, 32'd0);
    step();
    rstn = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (res_valid || busy) bad = 1'b1;
    end
    chk("wrst late done ignored", {31'd0, bad}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
